// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD request scheduler.
//   state_t      scheduler FSM encoding (IDLE / ISSUE / WAIT / RESP)
//   GCD_WIDTH    default operand/result width
//   GCD_NREQ     default number of requesters
//   GCD_TIMEOUT  default engine cycle budget before the request is aborted
package gcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int GCD_WIDTH   = 8;
  localparam int GCD_NREQ    = 4;
  localparam int GCD_TIMEOUT = 512;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req    in   NREQ  pending request vector
//   ptr    in   IDW   highest-priority requester this round
//   grant  out  NREQ  one-hot grant (all zero when nothing is pending)
//   idx    out  IDW   index of the granted requester
//   any    out  1     at least one request pending
// The search starts at ptr and wraps NREQ-1 -> 0. The pointer register
// itself lives in the scheduler.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// gcd_scheduler: shares one subtractive GCD engine between NREQ requesters.
//   CLK100MHZ   in   1           system clock
//   RST         in   1           synchronous active-high reset
//   req_valid   in   NREQ        per-requester request
//   req_a/b     in   NREQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready   out  NREQ        one-hot accept, high in the grant cycle
//   eng_start   out  1           one-cycle engine start
//   eng_a/b     out  WIDTH       engine operands, held while the engine runs
//   eng_abort   out  1           one-cycle abort after a timeout
//   eng_done    in   1           engine result valid pulse
//   eng_result  in   WIDTH       engine GCD
//   resp_valid  out  1           response valid, held until resp_ready
//   resp_ready  in   1           response consumer ready
//   resp_id     out  IDW         requester index of the response
//   resp_gcd    out  WIDTH       result (0 on timeout)
//   resp_err    out  1           response is a timeout
//   busy        out  1           scheduler not idle
//   dbg_state   out  2           current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requests: req_valid[i] && req_ready[i]; req_ready is only ever
// raised in IDLE, for one requester, and operands are sampled in that cycle.
// Responses: resp_valid && resp_ready; once raised, resp_valid and the
// response fields stay constant until the transfer.
module gcd_scheduler
  import gcd_pkg::*;
#(
  parameter int NREQ    = GCD_NREQ,
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = GCD_TIMEOUT,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK100MHZ,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  eng_start,
  output logic [WIDTH-1:0]      eng_a,
  output logic [WIDTH-1:0]      eng_b,
  output logic                  eng_abort,
  input  logic                  eng_done,
  input  logic [WIDTH-1:0]      eng_result,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_gcd,
  output logic                  resp_err,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    to_cnt;

  logic [NREQ-1:0]  arb_grant;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sel_a = req_a[int'(arb_idx)*WIDTH +: WIDTH];
  assign sel_b = req_b[int'(arb_idx)*WIDTH +: WIDTH];

  // The accept must coincide with the cycle the operands are captured, so it
  // is decoded from the registered state rather than registered itself.
  assign req_ready = (state == S_IDLE && !RST) ? arb_grant : '0;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      to_cnt     <= '0;
      eng_start  <= 1'b0;
      eng_abort  <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_gcd   <= '0;
      resp_err   <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            rr_ptr  <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
            resp_id <= arb_idx;
            if (sel_a == '0 || sel_b == '0) begin
              // gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0: the OR covers all three.
              resp_gcd   <= sel_a | sel_b;
              resp_err   <= 1'b0;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else begin
              eng_a     <= sel_a;
              eng_b     <= sel_b;
              eng_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last budget cycle still counts as success.
          if (eng_done) begin
            resp_gcd   <= eng_result;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (to_cnt == TO_LAST) begin
            eng_abort  <= 1'b1;
            resp_gcd   <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_scheduler.sv
module tb_gcd_scheduler;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int IDW     = 2;
  localparam int EW      = 16 + 1 + 8 + 8;
  localparam int BUDGET  = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  eng_start;
  logic [WIDTH-1:0]      eng_a;
  logic [WIDTH-1:0]      eng_b;
  logic                  eng_abort;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_result;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_gcd;
  logic                  resp_err;
  logic                  busy;
  logic [1:0]            dbg_state;

  gcd_scheduler #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK100MHZ  (clk),
    .RST        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_abort  (eng_abort),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_gcd   (resp_gcd),
    .resp_err   (resp_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];     // {latency[15:0], err, id[7:0], gcd[7:0]}
  int grant_q[$];
  int lat_q[$];
  int model_ptr = 0;
  int starts_exp = 0;
  int aborts_exp = 0;
  int starts_seen = 0;
  int aborts_seen = 0;
  int last_grant_cyc = 0;
  int rmode = 0;
  int hold_cnt = 0;

  logic [WIDTH-1:0] ta[NREQ];
  logic [WIDTH-1:0] tb_op[NREQ];
  int               tl[NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // ---------------- engine model ----------------
  int               eng_cnt = 0;
  logic [WIDTH-1:0] held_a;
  logic [WIDTH-1:0] held_b;

  initial begin
    eng_done   = 1'b0;
    eng_result = '0;
  end

  always @(posedge clk) begin
    #1;
    eng_done = 1'b0;
    if (rst) begin
      eng_cnt = 0;
    end else begin
      if (eng_abort) begin
        aborts_seen++;
        eng_cnt = 0;
      end
      if (eng_start) begin
        starts_seen++;
        held_a = eng_a;
        held_b = eng_b;
        if (lat_q.size() == 0) begin
          fail("unexpected_eng_start");
          eng_cnt = 0;
        end else begin
          eng_cnt = lat_q.pop_front();
        end
      end else if (eng_cnt > 0) begin
        chk("eng_a_stable", eng_a, held_a);
        chk("eng_b_stable", eng_b, held_b);
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done   = 1'b1;
          eng_result = WIDTH'(ref_gcd(held_a, held_b));
        end
      end
    end
  end

  // ---------------- response consumer ----------------
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: resp_ready = 1'b1;
      1: resp_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (resp_valid && hold_cnt < 5) begin
          resp_ready = 1'b0;
          hold_cnt++;
        end else begin
          resp_ready = 1'b1;
          if (!resp_valid) hold_cnt = 0;
        end
      end
    endcase
  end

  // ---------------- monitor ----------------
  logic             prev_valid = 1'b0;
  logic             hold_flag  = 1'b0;
  logic [IDW-1:0]   h_id;
  logic [WIDTH-1:0] h_gcd;
  logic             h_err;
  logic [EW-1:0]    e;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      hold_flag  = 1'b0;
    end else begin
      if (resp_valid) begin
        chk("no_grant_in_resp", req_ready, 0);
        chk("busy_in_resp", busy, 1);
      end
      if (hold_flag) begin
        chk("hold_valid", resp_valid, 1);
        chk("hold_data", {resp_id, resp_gcd, resp_err}, {h_id, h_gcd, h_err});
      end
      if (resp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_resp");
        end else begin
          e = exp_q[0];
          chk("latency", cyc - last_grant_cyc, e[32:17]);
          chk("abort_pulse", eng_abort, e[16]);
        end
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          fail("resp_without_expectation");
        end else begin
          e = exp_q.pop_front();
          chk("resp_id", resp_id, e[15:8]);
          chk("resp_gcd", resp_gcd, e[7:0]);
          chk("resp_err", resp_err, e[16]);
        end
      end
      hold_flag  = resp_valid && !resp_ready;
      h_id       = resp_id;
      h_gcd      = resp_gcd;
      h_err      = resp_err;
      prev_valid = resp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input int a, input int b, input int lat);
    ta[i]    = WIDTH'(a);
    tb_op[i] = WIDTH'(b);
    tl[i]    = lat;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_abort"}, eng_abort, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_resp_id"}, resp_id, 0);
    chk({tag, "_resp_gcd"}, resp_gcd, 0);
    chk({tag, "_eng_ab"}, {eng_a, eng_b}, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // Predicts service order from the round-robin rule, queues expectations,
  // then presents the requests and drops each one once it is accepted.
  task automatic run_batch(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend = mask;
    logic [NREQ-1:0] granted;
    int p = model_ptr;
    int g, gv, lat, elat;
    bit bypass, err;
    int budget;
    while (pend != 0) begin
      g = 0;
      for (int k = 0; k < NREQ; k++) begin
        int j = (p + k) % NREQ;
        if (pend[j]) begin
          g = j;
          break;
        end
      end
      bypass = (ta[g] == 0) || (tb_op[g] == 0);
      lat    = tl[g];
      err    = !bypass && (lat > TIMEOUT);
      gv     = err ? 0 : ref_gcd(ta[g], tb_op[g]);
      elat   = bypass ? 1 : (err ? TIMEOUT + 2 : lat + 2);
      exp_q.push_back({16'(elat), err, 8'(g), 8'(gv)});
      grant_q.push_back(g);
      if (!bypass) begin
        lat_q.push_back(lat);
        starts_exp++;
      end
      if (err) aborts_exp++;
      pend[g] = 1'b0;
      p = (g + 1) % NREQ;
    end
    model_ptr = p;

    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = ta[i];
      req_b[i*WIDTH +: WIDTH] = tb_op[i];
    end
    req_valid = mask;

    budget = 0;
    while (req_valid != 0 && budget < BUDGET) begin
      @(negedge clk);
      granted = req_ready;
      if (granted != 0) begin
        last_grant_cyc = cyc;
        if (grant_q.size() == 0) fail("unexpected_grant");
        else chk("grant", granted, 1 << grant_q.pop_front());
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (granted[i]) begin
          req_valid[i] = 1'b0;
          req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      budget++;
    end
    if (req_valid != 0) begin
      fail("grant_timeout");
      req_valid = '0;
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < BUDGET) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      fail("response_timeout");
      exp_q.delete();
    end
    grant_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int m;
    bit got;
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Round robin from pointer 0: served 0,1,2,3.
    set_req(0, 12, 8, 5);
    set_req(1, 9, 6, 7);
    set_req(2, 35, 14, 4);
    set_req(3, 17, 5, 9);
    run_batch(4'b1111);

    // Single request, 10-cycle engine: response 12 cycles after grant.
    set_req(0, 48, 18, 10);
    run_batch(4'b0001);

    // Zero-operand bypass: no engine start.
    set_req(1, 0, 21, 1);
    run_batch(4'b0010);
    set_req(2, 0, 0, 1);
    run_batch(4'b0100);
    set_req(3, 33, 0, 1);
    run_batch(4'b1000);
    chk("bypass_no_start", starts_seen, starts_exp);

    // Timeout: engine silent; done exactly on the last budget cycle wins.
    set_req(3, 40, 30, 1000);
    run_batch(4'b1000);
    set_req(0, 40, 30, TIMEOUT);
    run_batch(4'b0001);
    set_req(1, 40, 30, TIMEOUT + 1);
    run_batch(4'b0010);
    chk("timeout_aborts", aborts_seen, aborts_exp);

    // Backpressure: consumer stalls 5 cycles on every response.
    rmode = 2;
    set_req(0, 27, 18, 6);
    set_req(2, 0, 5, 1);
    run_batch(4'b0101);

    // Randomized batches with random backpressure.
    rmode = 1;
    for (int n = 0; n < 25; n++) begin
      m = $urandom_range(1, 15);
      for (int i = 0; i < NREQ; i++)
        set_req(i, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255),
                ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255),
                $urandom_range(1, 20));
      run_batch(NREQ'(m));
    end

    // Reset while the engine is running.
    rmode = 0;
    @(posedge clk);
    #1;
    req_a[1*WIDTH +: WIDTH] = 8'd100;
    req_b[1*WIDTH +: WIDTH] = 8'd75;
    req_valid = 4'b0010;
    lat_q.push_back(1000);
    starts_exp++;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready[1];
    end
    if (!got) fail("mid_wait_grant_timeout");
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_in_wait", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("mid_wait_reset");
    model_ptr = 0;
    lat_q.delete();
    set_req(2, 10, 4, 6);
    run_batch(4'b0100);

    repeat (4) @(posedge clk);
    chk("total_starts", starts_seen, starts_exp);
    chk("total_aborts", aborts_seen, aborts_exp);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
